// File: rtl/deserializer_pkg.sv
// Shared types and elaboration-time helpers for the deserializer slice.
package gray_area_package;
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } state_t;
endpackage

package deserializer_pkg;
  // Smallest p with 2^p >= data_width + p + 1.
  function automatic int unsigned hamming_code_bits(input int unsigned dw);
    int unsigned p;
    p = 0;
    for (int unsigned i = 1; i < 32; i++)
      if (p == 0 && (32'd1 << i) >= dw + i + 1) p = i;
    return p;
  endfunction

  // Codeword position (1-based) carrying data bit k: the k-th non-power-of-two.
  function automatic int unsigned hamming_data_pos(input int unsigned k);
    int unsigned pos;
    int unsigned cnt;
    pos = 0;
    cnt = 0;
    for (int unsigned p = 3; p < 2048; p++)
      if (pos == 0 && (p & (p - 1)) != 0) begin
        if (cnt == k) pos = p;
        cnt++;
      end
    return pos;
  endfunction
endpackage

// File: rtl/deserializer_if.sv
// Serial-in / parallel-out bundle for the deserializer.
interface deserializer_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  serial_in;
  logic                  enable;
  logic                  start;
  logic [DATA_WIDTH-1:0] parallel_out;
  logic                  valid_out;
  logic                  err_corrected;
  logic                  err_uncorrectable;

  modport master (
    output serial_in, enable, start,
    input  parallel_out, valid_out, err_corrected, err_uncorrectable
  );

  modport slave (
    input  serial_in, enable, start,
    output parallel_out, valid_out, err_corrected, err_uncorrectable
  );
endinterface

// File: rtl/deserializer_hamming_decode.sv
// Registered single-error-correcting Hamming decode of one received codeword.
module hamming_decode
  import deserializer_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH  = 8,
  localparam int unsigned CODE_BITS   = hamming_code_bits(DATA_WIDTH),
  localparam int unsigned CODED_WIDTH = DATA_WIDTH + CODE_BITS
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic [CODED_WIDTH-1:0] code_i,
  input  logic                   valid_i,
  output logic [DATA_WIDTH-1:0]  data_o,
  output logic                   err_corrected_o,
  output logic                   err_uncorrectable_o,
  output logic                   valid_o
);

  // code_i carries the payload in its upper bits and the parity field below it.
  logic [DATA_WIDTH-1:0]  rx_data;
  logic [DATA_WIDTH-1:0]  fix_data;
  logic [CODE_BITS-1:0]   rx_par;
  logic [CODE_BITS-1:0]   syn;
  logic [CODED_WIDTH-1:0] cw;
  logic                   unc;
  logic                   cor;

  assign rx_data = code_i[CODED_WIDTH-1 -: DATA_WIDTH];
  assign rx_par  = code_i[CODE_BITS-1:0];

  function automatic logic [CODED_WIDTH-1:0] pmask(input int unsigned i);
    logic [CODED_WIDTH-1:0] m;
    m = '0;
    for (int unsigned p = 1; p <= CODED_WIDTH; p++)
      if (((p >> i) & 1) != 0) m = m | (CODED_WIDTH'(1) << (p - 1));
    return m;
  endfunction

  // cw bit j holds codeword position j+1.
  for (genvar k = 0; k < DATA_WIDTH; k++) begin : g_data
    localparam int unsigned P = hamming_data_pos(k);
    assign cw[P-1]     = rx_data[k];
    assign fix_data[k] = rx_data[k] ^ (syn == CODE_BITS'(P));
  end

  for (genvar i = 0; i < CODE_BITS; i++) begin : g_par
    localparam logic [CODED_WIDTH-1:0] MASK = pmask(i);
    assign cw[(1 << i) - 1] = rx_par[i];
    assign syn[i]           = ^(cw & MASK);
  end

  assign unc = 32'(syn) > CODED_WIDTH;
  assign cor = (syn != '0) && !unc;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      data_o              <= '0;
      err_corrected_o     <= 1'b0;
      err_uncorrectable_o <= 1'b0;
      valid_o             <= 1'b0;
    end else begin
      valid_o <= valid_i;
      if (valid_i) begin
        data_o              <= fix_data;
        err_corrected_o     <= cor;
        err_uncorrectable_o <= unc;
      end
    end
  end

endmodule

// File: rtl/deserializer.sv
// Framed serial-to-parallel converter with optional Hamming correction stage.
module deserializer
  import deserializer_pkg::*;
  import gray_area_package::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned HAS_ECC    = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  serial_in_i,
  input  logic                  enable_i,
  input  logic                  start_i,
  output logic [DATA_WIDTH-1:0] parallel_out_o,
  output logic                  valid_out_o,
  output logic                  err_corrected_o,
  output logic                  err_uncorrectable_o
);

  localparam int unsigned CODE_BITS = hamming_code_bits(DATA_WIDTH);
  localparam int unsigned N         = (HAS_ECC != 0) ? DATA_WIDTH + CODE_BITS : DATA_WIDTH;
  localparam int unsigned CNT_W     = $clog2(N + 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [N-1:0]     shreg;
  logic [N-1:0]     shreg_next;
  logic             last_bit;
  logic             frame_done;

  always_comb begin
    shreg_next = {shreg[N-2:0], serial_in_i};
    last_bit   = enable_i && !start_i && (state == ST_RECV) && (cnt == CNT_W'(N - 1));
  end

  // A start bit always wins: it opens a frame from IDLE or aborts one in RECV.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      shreg      <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (enable_i && start_i) begin
        state <= ST_RECV;
        cnt   <= CNT_W'(1);
        shreg <= N'(serial_in_i);
      end else if (enable_i && state == ST_RECV) begin
        shreg <= shreg_next;
        if (last_bit) begin
          state      <= ST_IDLE;
          cnt        <= '0;
          frame_done <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  if (HAS_ECC != 0) begin : g_ecc
    // Decoder samples shreg while frame_done is high, before a back-to-back frame overwrites it.
    hamming_decode #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_decode (
      .clk_i              (clk_i),
      .rst_n_i            (rst_n_i),
      .code_i             (shreg),
      .valid_i            (frame_done),
      .data_o             (parallel_out_o),
      .err_corrected_o    (err_corrected_o),
      .err_uncorrectable_o(err_uncorrectable_o),
      .valid_o            (valid_out_o)
    );
  end else begin : g_raw
    logic [DATA_WIDTH-1:0] data_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        data_q <= '0;
      end else if (last_bit) begin
        data_q <= shreg_next[DATA_WIDTH-1:0];
      end
    end

    assign parallel_out_o      = data_q;
    assign valid_out_o         = frame_done;
    assign err_corrected_o     = 1'b0;
    assign err_uncorrectable_o = 1'b0;
  end

endmodule

// File: tb/tb_deserializer.sv
// Randomized self-checking bench: one plain and one ECC deserializer against a frame-level model.
module tb_deserializer;
  localparam int unsigned DW = 8;

  typedef struct {
    logic [7:0]  d;
    logic        c;
    logic        u;
    int unsigned cyc;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int unsigned cyc = 0;
  int          tests = 0;
  int          fails = 0;
  int unsigned last0 = 0;
  int unsigned last1 = 0;
  ev_t         obs0[$];
  ev_t         exp0[$];
  ev_t         obs1[$];
  ev_t         exp1[$];

  deserializer_if #(.DATA_WIDTH(DW)) if0 ();
  deserializer_if #(.DATA_WIDTH(DW)) if1 ();

  deserializer #(.DATA_WIDTH(DW), .HAS_ECC(0)) dut0 (
    .clk_i(clk), .rst_n_i(rst_n),
    .serial_in_i(if0.serial_in), .enable_i(if0.enable), .start_i(if0.start),
    .parallel_out_o(if0.parallel_out), .valid_out_o(if0.valid_out),
    .err_corrected_o(if0.err_corrected), .err_uncorrectable_o(if0.err_uncorrectable)
  );

  deserializer #(.DATA_WIDTH(DW), .HAS_ECC(1)) dut1 (
    .clk_i(clk), .rst_n_i(rst_n),
    .serial_in_i(if1.serial_in), .enable_i(if1.enable), .start_i(if1.start),
    .parallel_out_o(if1.parallel_out), .valid_out_o(if1.valid_out),
    .err_corrected_o(if1.err_corrected), .err_uncorrectable_o(if1.err_uncorrectable)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (if0.valid_out === 1'b1)
      obs0.push_back('{if0.parallel_out, if0.err_corrected, if0.err_uncorrectable, cyc});
    if (if1.valid_out === 1'b1)
      obs1.push_back('{if1.parallel_out, if1.err_corrected, if1.err_uncorrectable, cyc});
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive0(input logic en, input logic st, input logic b);
    if0.enable = en; if0.start = st; if0.serial_in = b;
    @(posedge clk);
    #1;
    if (en) last0 = cyc;
    if0.enable = 1'b0; if0.start = 1'b0; if0.serial_in = 1'b0;
  endtask

  task automatic drive1(input logic en, input logic st, input logic b);
    if1.enable = en; if1.start = st; if1.serial_in = b;
    @(posedge clk);
    #1;
    if (en) last1 = cyc;
    if1.enable = 1'b0; if1.start = 1'b0; if1.serial_in = 1'b0;
  endtask

  // Plain frame: payload MSB first; the output follows one cycle after the last bit.
  task automatic send0(input logic [7:0] d, input int nbits, input int gap_at, input int gap_len);
    for (int i = 0; i < nbits; i++) begin
      if (i == gap_at) repeat (gap_len) drive0(1'b0, 1'b0, 1'($urandom_range(0, 1)));
      drive0(1'b1, (i == 0), d[7-i]);
    end
    if (nbits == 8) exp0.push_back('{d, 1'b0, 1'b0, last0});
  endtask

  // Position-indexed codeword (bit p = position p, bit 0 unused).
  function automatic logic [12:0] encode(input logic [7:0] d);
    logic [12:0] v;
    logic        par;
    int          k;
    v = '0;
    k = 0;
    for (int p = 1; p <= 12; p++)
      if ((p & (p - 1)) != 0) begin
        v[p] = d[k];
        k++;
      end
    for (int i = 0; i < 4; i++) begin
      par = 1'b0;
      for (int p = 1; p <= 12; p++)
        if (((p >> i) & 1) != 0) par = par ^ v[p];
      v[1 << i] = par;
    end
    return v;
  endfunction

  function automatic logic [7:0] pos_data(input logic [12:0] v);
    logic [7:0] d;
    int         k;
    d = '0;
    k = 0;
    for (int p = 1; p <= 12; p++)
      if ((p & (p - 1)) != 0) begin
        d[k] = v[p];
        k++;
      end
    return d;
  endfunction

  // ECC frame: payload MSB first, then parity bits 3..0; expectation from the syndrome rules.
  task automatic send1(input logic [12:0] v, input int gap_at, input int gap_len, input bit expect_out);
    logic [11:0] f;
    int          syn;
    ev_t         e;
    logic [12:0] vc;
    f = {pos_data(v), v[8], v[4], v[2], v[1]};
    for (int i = 0; i < 12; i++) begin
      if (i == gap_at) repeat (gap_len) drive1(1'b0, 1'b0, 1'($urandom_range(0, 1)));
      drive1(1'b1, (i == 0), f[11-i]);
    end
    syn = 0;
    for (int p = 1; p <= 12; p++) if (v[p]) syn = syn ^ p;
    e = '{pos_data(v), 1'b0, 1'b0, last1 + 1};
    if (syn != 0 && syn <= 12) begin
      vc = v;
      vc[syn] = ~vc[syn];
      e.d = pos_data(vc);
      e.c = 1'b1;
    end else if (syn > 12) begin
      e.u = 1'b1;
    end
    if (expect_out) exp1.push_back(e);
  endtask

  task automatic clear_queues();
    obs0.delete(); exp0.delete(); obs1.delete(); exp1.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(3);
    tests++;
    if ({if0.parallel_out, if0.valid_out, if0.err_corrected, if0.err_uncorrectable} !== 11'd0) begin
      fails++;
      $display("FAIL reset_plain: got out=%h v=%b c=%b u=%b, expected all 0",
               if0.parallel_out, if0.valid_out, if0.err_corrected, if0.err_uncorrectable);
    end
    tests++;
    if ({if1.parallel_out, if1.valid_out, if1.err_corrected, if1.err_uncorrectable} !== 11'd0) begin
      fails++;
      $display("FAIL reset_ecc: got out=%h v=%b c=%b u=%b, expected all 0",
               if1.parallel_out, if1.valid_out, if1.err_corrected, if1.err_uncorrectable);
    end
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_basic();
    clear_queues();
    send0(8'hA5, 8, -1, 0);
    idle(6);
    tests++;
    if (obs0.size() != 1) begin
      fails++;
      $display("FAIL basic_count: got %0d pulses, expected 1", obs0.size());
    end
    if (obs0.size() >= 1) begin
      tests++;
      if (obs0[0].d !== exp0[0].d || obs0[0].cyc != exp0[0].cyc) begin
        fails++;
        $display("FAIL basic_a5: got %h at cycle %0d, expected %h at cycle %0d",
                 obs0[0].d, obs0[0].cyc, exp0[0].d, exp0[0].cyc);
      end
    end
    tests++;
    if (if0.parallel_out !== 8'hA5) begin
      fails++;
      $display("FAIL basic_hold: got %h between pulses, expected a5", if0.parallel_out);
    end
  endtask

  task automatic test_gaps();
    clear_queues();
    send0(8'h3C, 8, 4, 3);
    idle(6);
    tests++;
    if (obs0.size() != 1) begin
      fails++;
      $display("FAIL gaps_count: got %0d pulses, expected 1", obs0.size());
    end
    if (obs0.size() >= 1) begin
      tests++;
      if (obs0[0].d !== 8'h3C || obs0[0].cyc != exp0[0].cyc) begin
        fails++;
        $display("FAIL gaps_3c: got %h at cycle %0d, expected 3c at cycle %0d",
                 obs0[0].d, obs0[0].cyc, exp0[0].cyc);
      end
    end
  endtask

  task automatic test_idle_ignore();
    clear_queues();
    repeat (10) drive0(1'b1, 1'b0, 1'($urandom_range(0, 1)));
    idle(3);
    tests++;
    if (obs0.size() != 0) begin
      fails++;
      $display("FAIL idle_ignore: got %0d pulses, expected 0", obs0.size());
    end
  endtask

  task automatic test_abort();
    clear_queues();
    send0(8'hFF, 5, -1, 0);
    send0(8'h81, 8, -1, 0);
    idle(6);
    tests++;
    if (obs0.size() != 1) begin
      fails++;
      $display("FAIL abort_count: got %0d pulses, expected 1", obs0.size());
    end
    if (obs0.size() >= 1) begin
      tests++;
      if (obs0[0].d !== 8'h81 || obs0[0].cyc != exp0[0].cyc) begin
        fails++;
        $display("FAIL abort_81: got %h at cycle %0d, expected 81 at cycle %0d",
                 obs0[0].d, obs0[0].cyc, exp0[0].cyc);
      end
    end
  endtask

  task automatic test_mid_reset();
    clear_queues();
    send0(8'hC7, 6, -1, 0);
    rst_n = 1'b0;
    idle(2);
    tests++;
    if ({if0.parallel_out, if0.valid_out, if1.parallel_out, if1.valid_out} !== 18'd0) begin
      fails++;
      $display("FAIL midreset_outputs: got out0=%h v0=%b out1=%h v1=%b, expected all 0",
               if0.parallel_out, if0.valid_out, if1.parallel_out, if1.valid_out);
    end
    rst_n = 1'b1;
    idle(1);
    // Two stray bits would finish the aborted frame if its state survived reset.
    drive0(1'b1, 1'b0, 1'b1);
    drive0(1'b1, 1'b0, 1'b0);
    send0(8'h12, 8, -1, 0);
    send1(encode(8'($urandom)), -1, 0, 1'b0);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    idle(6);
    tests++;
    if (obs0.size() != 1) begin
      fails++;
      $display("FAIL midreset_count: got %0d pulses, expected 1", obs0.size());
    end
    if (obs0.size() >= 1) begin
      tests++;
      if (obs0[0].d !== 8'h12 || obs0[0].cyc != exp0[0].cyc) begin
        fails++;
        $display("FAIL midreset_12: got %h at cycle %0d, expected 12 at cycle %0d",
                 obs0[0].d, obs0[0].cyc, exp0[0].cyc);
      end
    end
    tests++;
    if (obs1.size() != 0) begin
      fails++;
      $display("FAIL midreset_decode_flush: got %0d ecc pulses, expected 0", obs1.size());
    end
  endtask

  task automatic test_back_to_back();
    clear_queues();
    for (int n = 0; n < 30; n++)
      send0(8'($urandom), 8, $urandom_range(0, 10), $urandom_range(1, 3));
    idle(6);
    tests++;
    if (obs0.size() != exp0.size()) begin
      fails++;
      $display("FAIL b2b_count: got %0d pulses, expected %0d", obs0.size(), exp0.size());
    end
    for (int i = 0; i < obs0.size() && i < exp0.size(); i++) begin
      tests++;
      if (obs0[i].d !== exp0[i].d || obs0[i].cyc != exp0[i].cyc) begin
        fails++;
        $display("FAIL b2b[%0d]: got %h at cycle %0d, expected %h at cycle %0d",
                 i, obs0[i].d, obs0[i].cyc, exp0[i].d, exp0[i].cyc);
      end
    end
  endtask

  task automatic test_ecc_directed();
    logic [12:0] v;
    clear_queues();
    send1(encode(8'h5A), -1, 0, 1'b1);
    idle(3);
    v = encode(8'h5A);
    v[7] = ~v[7];
    send1(v, -1, 0, 1'b1);
    idle(6);
    tests++;
    if (obs1.size() != 2) begin
      fails++;
      $display("FAIL ecc_dir_count: got %0d pulses, expected 2", obs1.size());
    end
    if (obs1.size() >= 1) begin
      tests++;
      if (obs1[0].d !== 8'h5A || obs1[0].c !== 1'b0 || obs1[0].u !== 1'b0 || obs1[0].cyc != exp1[0].cyc) begin
        fails++;
        $display("FAIL ecc_clean_5a: got %h c=%b u=%b cycle %0d, expected 5a c=0 u=0 cycle %0d",
                 obs1[0].d, obs1[0].c, obs1[0].u, obs1[0].cyc, exp1[0].cyc);
      end
    end
    if (obs1.size() >= 2) begin
      tests++;
      if (obs1[1].d !== 8'h5A || obs1[1].c !== 1'b1 || obs1[1].u !== 1'b0 || obs1[1].cyc != exp1[1].cyc) begin
        fails++;
        $display("FAIL ecc_fix_d3: got %h c=%b u=%b cycle %0d, expected 5a c=1 u=0 cycle %0d",
                 obs1[1].d, obs1[1].c, obs1[1].u, obs1[1].cyc, exp1[1].cyc);
      end
    end
  endtask

  task automatic test_ecc_random();
    logic [12:0] v;
    int          p;
    clear_queues();
    for (int n = 0; n < 40; n++) begin
      v = encode(8'($urandom));
      repeat ($urandom_range(0, 2)) begin
        p = $urandom_range(1, 12);
        v[p] = ~v[p];
      end
      send1(v, $urandom_range(0, 16), $urandom_range(1, 2), 1'b1);
    end
    idle(6);
    tests++;
    if (obs1.size() != exp1.size()) begin
      fails++;
      $display("FAIL ecc_rand_count: got %0d pulses, expected %0d", obs1.size(), exp1.size());
    end
    for (int i = 0; i < obs1.size() && i < exp1.size(); i++) begin
      tests++;
      if (obs1[i].d !== exp1[i].d || obs1[i].c !== exp1[i].c || obs1[i].u !== exp1[i].u ||
          obs1[i].cyc != exp1[i].cyc) begin
        fails++;
        $display("FAIL ecc_rand[%0d]: got %h c=%b u=%b cycle %0d, expected %h c=%b u=%b cycle %0d",
                 i, obs1[i].d, obs1[i].c, obs1[i].u, obs1[i].cyc,
                 exp1[i].d, exp1[i].c, exp1[i].u, exp1[i].cyc);
      end
    end
  endtask

  initial begin
    if0.serial_in = 1'b0; if0.enable = 1'b0; if0.start = 1'b0;
    if1.serial_in = 1'b0; if1.enable = 1'b0; if1.start = 1'b0;
    test_reset();
    test_basic();
    test_gaps();
    test_idle_ignore();
    test_abort();
    test_mid_reset();
    test_back_to_back();
    test_ecc_directed();
    test_ecc_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
